// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between uart_rx, the receive FIFO and the core's UART port.
// Valid/ready: a byte moves on rd_* only on a rising clk edge where rd_valid and rd_ready are both 1.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int ERR_CNT_W  = 8
);
    logic [DATA_WIDTH-1:0]  uart_rx_data;
    logic                   uart_rx_valid;
    logic                   uart_rx_err;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic                   clr;
    logic [DEPTH_LOG2:0]    count;
    logic                   line_avail;
    logic                   overrun;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output uart_rx_data, uart_rx_valid, uart_rx_err, rd_ready, clr,
        input  rd_data, rd_valid, count, line_avail, overrun, err_cnt
    );

    modport slave (
        input  uart_rx_data, uart_rx_valid, uart_rx_err, rd_ready, clr,
        output rd_data, rd_valid, count, line_avail, overrun, err_cnt
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind uart_rx, with overrun,
// framing-error count and line-terminator tracking for line-oriented polling.
module uart_rx_fifo #(
    parameter int             DATA_WIDTH = 8,
    parameter int             DEPTH_LOG2 = 4,
    parameter logic [7:0]     EOL_CHAR   = 8'h0A,
    parameter int             ERR_CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_if.slave     bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         eol_cnt;
    logic                  overrun_q;
    logic [ERR_CNT_W-1:0]  err_q;

    logic full;
    logic empty;
    logic push_req;
    logic push_acc;
    logic pop;
    logic eol_in;
    logic eol_out;
    logic [DATA_WIDTH-1:0] head;

    always_comb begin
        full     = (cnt == CW'(DEPTH));
        empty    = (cnt == '0);
        head     = mem[rd_ptr];
        push_req = bus.uart_rx_valid && !bus.uart_rx_err;
        pop      = !empty && bus.rd_ready;
        // When full, a simultaneous pop frees the slot the push lands in.
        push_acc = push_req && (!full || pop);
        eol_in   = push_acc && (bus.uart_rx_data == DATA_WIDTH'(EOL_CHAR));
        eol_out  = pop && (head == DATA_WIDTH'(EOL_CHAR));
    end

    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            eol_cnt   <= '0;
            overrun_q <= 1'b0;
            err_q     <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)      rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            cnt     <= cnt + CW'(push_acc) - CW'(pop);
            eol_cnt <= eol_cnt + CW'(eol_in) - CW'(eol_out);
            if (push_req && !push_acc) overrun_q <= 1'b1;
            if (bus.uart_rx_err && err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
        end
    end

    // Storage carries no reset; entries are only observed through count.
    always_ff @(posedge clk) begin
        if (rst && !bus.clr && push_acc) mem[wr_ptr] <= bus.uart_rx_data;
    end

    assign bus.rd_data    = head;
    assign bus.rd_valid   = !empty;
    assign bus.count      = cnt;
    assign bus.line_avail = (eol_cnt != '0);
    assign bus.overrun    = overrun_q;
    assign bus.err_cnt    = err_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model compared on
// every falling edge, plus literal checks at the key points of each scenario.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int EW    = 8;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .ERR_CNT_W(EW)) bus ();

    uart_rx_fifo #(
        .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .EOL_CHAR(8'h0A), .ERR_CNT_W(EW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model
    logic [DW-1:0] exp_q[$];
    logic          m_overrun;
    int            m_err;
    logic          model_ok;

    initial begin
        model_ok  = 1'b0;
        m_overrun = 1'b0;
        m_err     = 0;
    end

    always @(posedge clk) begin
        if (!rst || bus.clr) begin
            exp_q.delete();
            m_overrun = 1'b0;
            m_err     = 0;
            model_ok  = 1'b1;
        end else begin
            if (bus.uart_rx_err && m_err < 255) m_err = m_err + 1;
            if (exp_q.size() > 0 && bus.rd_ready) void'(exp_q.pop_front());
            if (bus.uart_rx_valid && !bus.uart_rx_err) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(bus.uart_rx_data);
                else m_overrun = 1'b1;
            end
        end
    end

    function automatic logic m_line();
        foreach (exp_q[i]) if (exp_q[i] == 8'h0A) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare on every falling edge once the model is initialised
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_count", 32'(bus.count), 32'(exp_q.size()));
            chk("m_valid", 32'(bus.rd_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("m_data", 32'(bus.rd_data), 32'(exp_q[0]));
            chk("m_line", 32'(bus.line_avail), 32'(m_line()));
            chk("m_overrun", 32'(bus.overrun), 32'(m_overrun));
            chk("m_err", 32'(bus.err_cnt), 32'(m_err));
        end
    end

    // driver: apply inputs for one cycle, return 1 time unit after the edge
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic rdy, input logic c);
        bus.uart_rx_valid = v;
        bus.uart_rx_data  = d;
        bus.uart_rx_err   = e;
        bus.rd_ready      = rdy;
        bus.clr           = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = '0;
        bus.uart_rx_err   = 1'b0;
        bus.rd_ready      = 1'b0;
        bus.clr           = 1'b0;

        // reset held 3 cycles with strobes arriving
        cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_err", 32'(bus.err_cnt), 32'd0);
        chk("rst_line", 32'(bus.line_avail), 32'd0);

        // order and latency
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                chk("lat_valid", 32'(bus.rd_valid), 32'd1);
                chk("lat_data", 32'(bus.rd_data), 32'h61);
            end
            idle();
        end
        chk("abc_count", 32'(bus.count), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk("abc_data", 32'(bus.rd_data), 32'(8'h61 + i));
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("abc_empty", 32'(bus.rd_valid), 32'd0);
        chk("abc_count0", 32'(bus.count), 32'd0);

        // empty: push with rd_ready is a push only
        cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("emp_pushpop", 32'(bus.count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // overrun
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        idle();
        chk("ovr_count", 32'(bus.count), 32'd16);
        chk("ovr_flag", 32'(bus.overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovr_data", 32'(bus.rd_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("ovr_drained", 32'(bus.rd_valid), 32'd0);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovr_clr", 32'(bus.overrun), 32'd0);

        // full push + pop
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        chk("fpp_count", 32'(bus.count), 32'd16);
        chk("fpp_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("fpp_data", 32'(bus.rd_data), 32'(8'h20 + i));
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("fpp_last", 32'(bus.rd_data), 32'hAA);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("fpp_empty", 32'(bus.count), 32'd0);

        // line tracking and framing errors
        cyc(1'b1, 8'h68, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h69, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
        chk("line_count", 32'(bus.count), 32'd3);
        chk("line_err", 32'(bus.err_cnt), 32'd3);
        chk("line_avail", 32'(bus.line_avail), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("line_gone", 32'(bus.line_avail), 32'd0);

        // flush wins over push and pop
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h0A, 1'b0, 1'b1, 1'b1);
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_valid", 32'(bus.rd_valid), 32'd0);
        chk("clr_overrun", 32'(bus.overrun), 32'd0);
        chk("clr_err", 32'(bus.err_cnt), 32'd0);
        chk("clr_line", 32'(bus.line_avail), 32'd0);

        // error counter saturation
        for (int i = 0; i < 300; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        chk("sat_err", 32'(bus.err_cnt), 32'hFF);

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of uart_rx.
- Captures each byte uart_rx delivers, stores it in a first-word-fall-through FIFO, and offers it to the JPU core's memory-mapped UART port over a valid/ready handshake.
- Also reports overrun, framing errors and line-terminator availability, so firmware can poll for complete lines instead of single bytes.

Parameters:
DATA_WIDTH, 8 (`UART_DATA_WIDTH), byte width from uart_rx
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)
EOL_CHAR, 8'h0A, byte value counted as line terminator
ERR_CNT_W, 8, width of saturating framing-error counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
uart_rx_data  in  DATA_WIDTH  received byte from uart_rx
uart_rx_valid  in  1  one-cycle strobe, uart_rx_data valid
uart_rx_err  in  1  one-cycle framing-error strobe from uart_rx
rd_data  out  DATA_WIDTH  head-of-FIFO byte, valid while rd_valid=1
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts rd_data this cycle
clr  in  1  synchronous flush of FIFO and status
count  out  DEPTH_LOG2+1  entries currently stored, 0..DEPTH
line_avail  out  1  at least one EOL_CHAR byte stored
overrun  out  1  sticky: a byte was dropped because FIFO was full
err_cnt  out  ERR_CNT_W  saturating count of framing errors

Behaviour:
- Reset (rst=0 at a clk edge):
  - count=0, rd_valid=0, line_avail=0, overrun=0, err_cnt=0; rd_data don't-care.
  - Read/write pointers and the EOL counter are zeroed.
  - rst has priority over all other inputs, including in-flight push/pop.
- clr=1 (rst=1): same effect as reset on the following edge. Push and pop in that cycle are ignored.
- Push, when uart_rx_valid=1 and uart_rx_err=0:
  - Byte written at wr_ptr; wr_ptr increments mod DEPTH.
  - Visible on rd_valid/rd_data at edge N+1 for strobe at edge N.
  - No same-cycle bypass.
- Error strobe, uart_rx_err=1:
  - err_cnt increments, saturating at all-ones.
  - If uart_rx_valid is also 1, the byte is discarded (not stored, no overrun).
- Pop, when rd_valid=1 and rd_ready=1:
  - rd_ptr increments mod DEPTH.
  - The next entry appears on rd_data in the same cycle the edge completes (FWFT, combinational read of rd_ptr entry).
  - rd_ready while empty has no effect.
- Full (count==DEPTH), push and no pop: byte dropped, overrun<=1; count, pointers and stored data unchanged.
- Full, push and pop together: pop frees a slot, push accepted, count stays DEPTH, overrun unchanged.
- Empty, push and rd_ready together: push only; count 0->1.
- count arithmetic: count_next = count + push_acc - pop; never exceeds DEPTH or goes below 0.
- EOL tracking:
  - eol_cnt (DEPTH_LOG2+1 bits) +1 on an accepted push of EOL_CHAR, -1 on a pop whose rd_data==EOL_CHAR.
  - Both in one cycle: unchanged.
  - line_avail = (eol_cnt != 0), registered-equivalent (derived from the register).
- overrun clears only on rst or clr. err_cnt clears only on rst or clr.
- Pointer wrap: DEPTH_LOG2-bit pointers wrap naturally; full/empty are determined from count, not from pointer compare.

Test Plan:
- Reset: hold rst=0 for 3 cycles with uart_rx_valid pulsing -> count=0, rd_valid=0, overrun=0, err_cnt=0, line_avail=0 after release.
- Order and latency: push "abcdefg" (7 strobes, 1 idle cycle apart), rd_ready=0 -> count=7, rd_data=8'h61 one cycle after first strobe; then rd_ready=1 for 7 cycles -> reads 61..67 in order, rd_valid=0, count=0.
- Overrun: push 17 bytes 8'h00..8'h10, no pops -> count=16, overrun=1, then pops return 00..0F; 8'h10 is never seen.
- Full push+pop: fill 16 bytes, then in one cycle push 8'hAA with rd_ready=1 -> count stays 16, overrun=0, last popped byte after draining = 8'hAA; pointers wrap correctly.
- Line tracking and errors: push "hi\n", pulse uart_rx_err alone twice and once with uart_rx_valid (data 8'h0A) -> count=3, err_cnt=3, line_avail=1; pop 3 -> line_avail=0.
- Flush priority: fill 5 bytes, assert clr together with push and rd_ready -> next cycle count=0, rd_valid=0, overrun=0, err_cnt=0.
- Saturation: 300 uart_rx_err pulses -> err_cnt=8'hFF.
